// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: hazard/flush/PC-select control plus single-level IRQ entry and eret.
// Ports: EX/ID hazard and branch/jump inputs, IRQ request/enable -> stall, flushes, PCsel,
//        irq_ack, and the registered EPC, supervisor flag (super_mode) and saturating irq_cnt.
module pipeline_sequencer (
  input  logic        CLK,
  input  logic        reset,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_rt,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_valid,
  input  logic [1:0]  ID_PCsrc,
  input  logic        ID_Eret,
  input  logic        EX_BrTaken,
  input  logic [31:0] ID_PC,
  input  logic [31:0] EX_ConBA,
  input  logic        IRQsig,
  input  logic        IRQen,
  output logic        stall,
  output logic        IF_Flush,
  output logic        ID_Flush,
  output logic [2:0]  PCsel,
  output logic        super_mode,
  output logic        irq_ack,
  output logic [31:0] EPC,
  output logic [7:0]  irq_cnt
);

  typedef enum logic [1:0] {RUN, ENTER, ISR, EXIT} state_t;

  localparam logic [2:0] SEL_SEQ   = 3'd0;
  localparam logic [2:0] SEL_BR    = 3'd1;
  localparam logic [2:0] SEL_JUMP  = 3'd2;
  localparam logic [2:0] SEL_REG   = 3'd3;
  localparam logic [2:0] SEL_VEC   = 3'd4;
  localparam logic [2:0] SEL_EPC   = 3'd5;

  state_t state, state_nxt;
  logic   load_use;
  logic   take;

  assign load_use = EX_MemRd && (EX_rt != 5'd0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));
  // A request is only taken against a real ID instruction, so EPC always names
  // something worth re-executing; bubbles simply defer the request.
  assign take = (state == RUN) && IRQsig && IRQen && ID_valid;

  always_comb begin
    stall     = 1'b0;
    IF_Flush  = 1'b0;
    ID_Flush  = 1'b0;
    PCsel     = SEL_SEQ;
    irq_ack   = 1'b0;
    state_nxt = state;
    if (!reset) begin
      if (take) begin
        // The ID instruction is squashed and refetched from EPC, so any
        // load-use stall against it is moot.
        IF_Flush  = 1'b1;
        ID_Flush  = 1'b1;
        state_nxt = ENTER;
      end else if (state == ENTER) begin
        IF_Flush  = 1'b1;
        PCsel     = SEL_VEC;
        irq_ack   = 1'b1;
        state_nxt = ISR;
      end else begin
        if (state == EXIT)
          state_nxt = RUN;
        if (EX_BrTaken) begin
          IF_Flush = 1'b1;
          ID_Flush = 1'b1;
          PCsel    = SEL_BR;
        end else if (load_use) begin
          stall    = 1'b1;
          ID_Flush = 1'b1;
        end else if ((state == ISR) && ID_Eret) begin
          IF_Flush  = 1'b1;
          PCsel     = SEL_EPC;
          state_nxt = EXIT;
        end else if (ID_PCsrc == 2'd1) begin
          IF_Flush = 1'b1;
          PCsel    = SEL_JUMP;
        end else if ((ID_PCsrc == 2'd2) || ID_Eret) begin
          // Outside the ISR an eret is just a JR $26.
          IF_Flush = 1'b1;
          PCsel    = SEL_REG;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= RUN;
      EPC        <= 32'd0;
      super_mode <= 1'b0;
      irq_cnt    <= 8'd0;
    end else begin
      state <= state_nxt;
      if (take)
        // A taken branch in EX means ID is on the wrong path; resume at the target.
        EPC <= EX_BrTaken ? EX_ConBA : ID_PC;
      if (state == ENTER) begin
        super_mode <= 1'b1;
        if (irq_cnt != 8'hFF)
          irq_cnt <= irq_cnt + 8'd1;
      end
      if (state == EXIT)
        super_mode <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: expected control vectors queued per cycle, compared at negedge.
// Registered EPC/super_mode/irq_cnt compared just after the active edge.
module tb_pipeline_sequencer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        EX_MemRd;
  logic [4:0]  EX_rt, ID_rs, ID_rt;
  logic        ID_valid;
  logic [1:0]  ID_PCsrc;
  logic        ID_Eret, EX_BrTaken;
  logic [31:0] ID_PC, EX_ConBA;
  logic        IRQsig, IRQen;
  logic        stall, IF_Flush, ID_Flush, super_mode, irq_ack;
  logic [2:0]  PCsel;
  logic [31:0] EPC;
  logic [7:0]  irq_cnt;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];

  pipeline_sequencer dut (
    .CLK(CLK), .reset(reset), .EX_MemRd(EX_MemRd), .EX_rt(EX_rt), .ID_rs(ID_rs),
    .ID_rt(ID_rt), .ID_valid(ID_valid), .ID_PCsrc(ID_PCsrc), .ID_Eret(ID_Eret),
    .EX_BrTaken(EX_BrTaken), .ID_PC(ID_PC), .EX_ConBA(EX_ConBA), .IRQsig(IRQsig),
    .IRQen(IRQen), .stall(stall), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush),
    .PCsel(PCsel), .super_mode(super_mode), .irq_ack(irq_ack), .EPC(EPC), .irq_cnt(irq_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic clr();
    EX_MemRd = 0; EX_rt = 0; ID_rs = 0; ID_rt = 0; ID_valid = 1; ID_PCsrc = 0;
    ID_Eret = 0; EX_BrTaken = 0; ID_PC = 0; EX_ConBA = 0; IRQsig = 0; IRQen = 0;
  endtask

  // One clock: queue expected {stall,IF_Flush,ID_Flush,PCsel,irq_ack}, compare at
  // negedge, then return just after the next rising edge.
  task automatic cyc(input logic s, input logic fi, input logic fd,
                     input logic [2:0] pc, input logic ack, input string tag);
    logic [6:0] e, o;
    exp_q.push_back({s, fi, fd, pc, ack});
    @(negedge CLK);
    e = exp_q.pop_front();
    o = {stall, IF_Flush, ID_Flush, PCsel, irq_ack};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: {stall,IF,ID,PCsel,ack} got %b expected %b", tag, o, e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  initial begin
    clr();
    reset = 1;
    EX_MemRd = 1; EX_rt = 8; ID_rs = 8; IRQsig = 1; IRQen = 1;
    cyc(0, 0, 0, 3'd0, 0, "rst_comb0");
    cyc(0, 0, 0, 3'd0, 0, "rst_comb1");
    reset = 0;
    chk("rst_epc", EPC, 32'h0);
    chk("rst_super", {31'd0, super_mode}, 32'd0);
    chk("rst_cnt", {24'd0, irq_cnt}, 32'd0);

    // Hazards, branches, jumps in RUN.
    clr(); EX_MemRd = 1; EX_rt = 8; ID_rs = 8;
    cyc(1, 0, 1, 3'd0, 0, "load_use_rs");
    EX_rt = 0; ID_rs = 0;
    cyc(0, 0, 0, 3'd0, 0, "load_use_rt0");
    EX_rt = 9; ID_rt = 9; ID_rs = 3;
    cyc(1, 0, 1, 3'd0, 0, "load_use_rt");
    EX_BrTaken = 1; ID_PCsrc = 1;
    cyc(0, 1, 1, 3'd1, 0, "branch_pri");
    clr(); ID_PCsrc = 1;
    cyc(0, 1, 0, 3'd2, 0, "jump_j");
    ID_PCsrc = 2;
    cyc(0, 1, 0, 3'd3, 0, "jump_jr");
    ID_PCsrc = 1; EX_MemRd = 1; EX_rt = 4; ID_rs = 4;
    cyc(1, 0, 1, 3'd0, 0, "stall_over_jump");
    clr(); ID_Eret = 1;
    cyc(0, 1, 0, 3'd3, 0, "eret_in_run");

    // IRQ deferral and entry.
    clr(); IRQsig = 1; IRQen = 1; ID_valid = 0;
    cyc(0, 0, 0, 3'd0, 0, "irq_defer0");
    cyc(0, 0, 0, 3'd0, 0, "irq_defer1");
    ID_valid = 1; IRQen = 0;
    cyc(0, 0, 0, 3'd0, 0, "irq_disabled");
    IRQen = 1; ID_PC = 32'h40; EX_MemRd = 1; EX_rt = 8; ID_rs = 8;
    cyc(0, 1, 1, 3'd0, 0, "take_over_stall");
    chk("epc_id_pc", EPC, 32'h40);
    EX_MemRd = 0;
    cyc(0, 1, 0, 3'd4, 1, "enter");
    chk("enter_super", {31'd0, super_mode}, 32'd1);
    chk("enter_cnt", {24'd0, irq_cnt}, 32'd1);

    // ISR: no nesting, eret deferred by branch/stall, then EXIT.
    cyc(0, 0, 0, 3'd0, 0, "isr_nonest0");
    cyc(0, 0, 0, 3'd0, 0, "isr_nonest1");
    ID_Eret = 1; EX_BrTaken = 1;
    cyc(0, 1, 1, 3'd1, 0, "eret_vs_branch");
    EX_BrTaken = 0; EX_MemRd = 1; EX_rt = 5; ID_rt = 5;
    cyc(1, 0, 1, 3'd0, 0, "eret_vs_stall");
    EX_MemRd = 0;
    cyc(0, 1, 0, 3'd5, 0, "eret");
    ID_Eret = 0;
    cyc(0, 0, 0, 3'd0, 0, "exit_no_take");
    chk("exit_super", {31'd0, super_mode}, 32'd0);
    ID_PC = 32'h80; EX_BrTaken = 1; EX_ConBA = 32'h100;
    cyc(0, 1, 1, 3'd0, 0, "take_after_exit");
    chk("epc_conba", EPC, 32'h100);
    EX_BrTaken = 0;
    cyc(0, 1, 0, 3'd4, 1, "enter2");
    chk("enter2_cnt", {24'd0, irq_cnt}, 32'd2);

    // Reset inside ISR abandons the sequence.
    reset = 1; ID_Eret = 1;
    cyc(0, 0, 0, 3'd0, 0, "rst_in_isr");
    reset = 0; ID_Eret = 0;
    chk("rst_isr_epc", EPC, 32'h0);
    chk("rst_isr_super", {31'd0, super_mode}, 32'd0);
    chk("rst_isr_cnt", {24'd0, irq_cnt}, 32'd0);
    cyc(0, 1, 1, 3'd0, 0, "take_after_rst");
    reset = 1;
    cyc(0, 0, 0, 3'd0, 0, "rst_in_enter");
    reset = 0;
    chk("rst_enter_cnt", {24'd0, irq_cnt}, 32'd0);
    chk("rst_enter_super", {31'd0, super_mode}, 32'd0);

    // 256 full sequences: counter must stop at 255.
    clr(); IRQsig = 1; IRQen = 1;
    for (int i = 0; i < 256; i++) begin
      ID_Eret = 0;
      cyc(0, 1, 1, 3'd0, 0, "sat_take");
      cyc(0, 1, 0, 3'd4, 1, "sat_enter");
      ID_Eret = 1;
      cyc(0, 1, 0, 3'd5, 0, "sat_eret");
      ID_Eret = 0;
      cyc(0, 0, 0, 3'd0, 0, "sat_exit");
      if (i == 254) chk("cnt_255", {24'd0, irq_cnt}, 32'd255);
    end
    chk("cnt_sat", {24'd0, irq_cnt}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
